// File: rtl/async_fifo_rctl.sv
// rtl/async_fifo_rctl.sv - dual-clock FIFO read-side pointer, flag and occupancy controller
module async_fifo_rctl #(
    parameter int ADDR_W    = 3,
    parameter int AEMPTY_TH = 1
) (
    input  logic              rclk,
    input  logic              rrst,
    input  logic              rget,
    input  logic [ADDR_W:0]   rq2_wptr,
    input  logic              rerr_clr,
    output logic              rrdy,
    output logic              rempty,
    output logic [ADDR_W-1:0] raddr,
    output logic [ADDR_W:0]   rptr,
    output logic [ADDR_W:0]   rcount,
    output logic              ralmost_empty,
    output logic              runderflow
);

    localparam int PW = ADDR_W + 1;
    localparam logic [PW-1:0] TH = PW'(AEMPTY_TH);

    logic [PW-1:0] r_bin;
    logic [PW-1:0] r_gray;
    logic          r_empty;
    logic [PW-1:0] r_count;
    logic          r_aempty;
    logic          r_uflow;

    logic          w_rinc;
    logic [PW-1:0] w_bin_nxt;
    logic [PW-1:0] w_gray_nxt;
    logic [PW-1:0] w_wbin;
    logic [PW-1:0] w_count_nxt;

    assign w_rinc      = rget & ~r_empty;
    assign w_bin_nxt   = r_bin + {{ADDR_W{1'b0}}, w_rinc};
    assign w_gray_nxt  = w_bin_nxt ^ (w_bin_nxt >> 1);
    // Occupancy is taken against the post-pop pointer so it is exact on the pop edge.
    assign w_count_nxt = w_wbin - w_bin_nxt;

    // Convert the synchronized Gray write pointer back to binary (MSB-down XOR chain).
    always_comb begin
        w_wbin         = '0;
        w_wbin[PW-1]   = rq2_wptr[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            w_wbin[i] = w_wbin[i+1] ^ rq2_wptr[i];
        end
    end

    // Read pointer in binary (RAM address) and Gray (crosses to the write domain).
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            r_bin  <= '0;
            r_gray <= '0;
        end else begin
            r_bin  <= w_bin_nxt;
            r_gray <= w_gray_nxt;
        end
    end

    // Registered empty, occupancy and almost-empty, all from the same post-pop comparison.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            r_empty  <= 1'b1;
            r_count  <= '0;
            r_aempty <= 1'b1;
        end else begin
            r_empty  <= (w_gray_nxt == rq2_wptr);
            r_count  <= w_count_nxt;
            r_aempty <= (w_count_nxt <= TH);
        end
    end

    // Sticky underflow: a new pop-while-empty wins over a clear in the same cycle.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            r_uflow <= 1'b0;
        end else if (rget & r_empty) begin
            r_uflow <= 1'b1;
        end else if (rerr_clr) begin
            r_uflow <= 1'b0;
        end
    end

    assign rempty        = r_empty;
    assign rrdy          = ~r_empty;
    assign raddr         = r_bin[ADDR_W-1:0];
    assign rptr          = r_gray;
    assign rcount        = r_count;
    assign ralmost_empty = r_aempty;
    assign runderflow    = r_uflow;

endmodule

// File: tb/tb_async_fifo_rctl.sv
// tb/tb_async_fifo_rctl.sv - randomized model-checked bench for async_fifo_rctl
module tb_async_fifo_rctl;

    logic       rclk = 1'b0;
    logic       clk_en = 1'b0;
    logic       rrst = 1'b0;
    logic       rget = 1'b0;
    logic       rerr_clr = 1'b0;
    logic [2:0] rq2_wptr;
    logic       rrdy, rempty, ralmost_empty, runderflow;
    logic [1:0] raddr;
    logic [2:0] rptr, rcount;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 0;

    // writer-side word count (mod 8), presented as a synchronized Gray pointer
    int w = 0;

    // model: number of words consumed, words held, sticky underflow
    int m_rd = 0;
    int m_cnt = 0;
    bit m_uf = 0;

    function automatic logic [2:0] gray3(input int b);
        logic [2:0] x;
        x = b[2:0];
        return x ^ (x >> 1);
    endfunction

    assign rq2_wptr = gray3(w);

    async_fifo_rctl #(.ADDR_W(2), .AEMPTY_TH(1)) dut (
        .rclk(rclk), .rrst(rrst), .rget(rget), .rq2_wptr(rq2_wptr),
        .rerr_clr(rerr_clr), .rrdy(rrdy), .rempty(rempty), .raddr(raddr),
        .rptr(rptr), .rcount(rcount), .ralmost_empty(ralmost_empty),
        .runderflow(runderflow)
    );

    always #5 if (clk_en) rclk = ~rclk;

    always @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            m_rd  = 0;
            m_cnt = 0;
            m_uf  = 0;
        end else begin
            if (rget && m_cnt == 0) m_uf = 1;
            else if (rerr_clr)      m_uf = 0;
            if (rget && m_cnt != 0) m_rd = (m_rd + 1) & 7;
            m_cnt = (w - m_rd) & 7;
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d at %0t", nm, got, exp, $time);
        end
    endtask

    always @(negedge rclk) begin
        if (chk_en) begin
            chk("rempty", 32'(rempty), 32'(m_cnt == 0));
            chk("rrdy", 32'(rrdy), 32'(m_cnt != 0));
            chk("rcount", 32'(rcount), 32'(m_cnt));
            chk("ralmost_empty", 32'(ralmost_empty), 32'(m_cnt <= 1));
            chk("raddr", 32'(raddr), 32'(m_rd % 4));
            chk("rptr", 32'(rptr), 32'(gray3(m_rd)));
            chk("runderflow", 32'(runderflow), 32'(m_uf));
        end
    end

    task automatic step();
        @(posedge rclk);
        #2;
    endtask

    logic [2:0] tbl [9] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111,
                            3'b101, 3'b100, 3'b000, 3'b001};

    initial begin
        // reset with no clock running
        #3 rrst = 1'b1;
        #1;
        chk("t1_rempty", 32'(rempty), 1);
        chk("t1_rrdy", 32'(rrdy), 0);
        chk("t1_rptr", 32'(rptr), 0);
        chk("t1_rcount", 32'(rcount), 0);
        chk("t1_aempty", 32'(ralmost_empty), 1);
        chk("t1_uflow", 32'(runderflow), 0);
        #1 rrst = 1'b0;
        chk_en = 1;
        clk_en = 1'b1;

        // three words become visible, then drained
        w = 3;
        step();
        chk("t2_rempty", 32'(rempty), 0);
        chk("t2_rcount", 32'(rcount), 3);
        chk("t2_aempty", 32'(ralmost_empty), 0);
        chk("t2_raddr0", 32'(raddr), 0);
        rget = 1'b1;
        step();
        chk("t2_raddr1", 32'(raddr), 1);
        chk("t2_rptr1", 32'(rptr), 3'b001);
        step();
        chk("t2_raddr2", 32'(raddr), 2);
        chk("t2_rptr2", 32'(rptr), 3'b011);
        step();
        chk("t2_rptr3", 32'(rptr), 3'b010);
        chk("t2_empty3", 32'(rempty), 1);
        chk("t2_count3", 32'(rcount), 0);

        // underflow set, set-beats-clear, then clear
        step();
        chk("t4_uflow", 32'(runderflow), 1);
        chk("t4_rptr", 32'(rptr), 3'b010);
        rget = 1'b0;
        step();
        chk("t4_hold", 32'(runderflow), 1);
        rget = 1'b1; rerr_clr = 1'b1;
        step();
        chk("t4_setwins", 32'(runderflow), 1);
        rget = 1'b0;
        step();
        chk("t4_clr", 32'(runderflow), 0);
        rerr_clr = 1'b0;

        // pop last word while a new word arrives
        w = 4;
        step();
        chk("t5_count", 32'(rcount), 1);
        rget = 1'b1; w = 5;
        step();
        chk("t5_rempty", 32'(rempty), 0);
        chk("t5_count2", 32'(rcount), 1);
        chk("t5_raddr", 32'(raddr), 0);
        chk("t5_rptr", 32'(rptr), 3'b110);
        rget = 1'b0;

        // reset between edges with two words held
        w = 6;
        step();
        chk("t6_count", 32'(rcount), 2);
        rrst = 1'b1;
        #1;
        chk("t6_rst_empty", 32'(rempty), 1);
        chk("t6_rst_count", 32'(rcount), 0);
        chk("t6_rst_rptr", 32'(rptr), 0);
        w = 2;
        rrst = 1'b0;
        step();
        chk("t6_empty", 32'(rempty), 0);
        chk("t6_count2", 32'(rcount), 2);
        chk("t6_rptr", 32'(rptr), 0);

        // full FIFO (pointers differ only in MSB), then stream 9 words through the wrap
        w = 4;
        step();
        chk("t3_count", 32'(rcount), 4);
        chk("t3_empty", 32'(rempty), 0);
        rget = 1'b1;
        for (int i = 0; i < 9; i++) begin
            w = (w + 1) & 7;
            step();
            chk("t3_rptr", 32'(rptr), 32'(tbl[i]));
        end
        rget = 1'b0;

        // randomized traffic with occasional clears and resets
        repeat (3000) begin
            step();
            rget = ($urandom_range(0, 2) != 0);
            rerr_clr = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 1) == 1 && ((w - m_rd) & 7) < 4) w = (w + 1) & 7;
            if ($urandom_range(0, 299) == 0) begin
                rrst = 1'b1;
                w = 0;
                #1 rrst = 1'b0;
            end
        end

        step();
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
